// File: rtl/collision_detect.sv
`default_nettype none
// ============================================================================
// Module   : collision_detect
// Purpose  : Tests the obstacle-layer pixel stream against the lander's box
//            and reports crash / landed / overlap count once per frame.
// Option   : define COLLISION_FIRST_HIT_EN to report the first hit pixel on
//            hit_x/hit_y (otherwise those outputs are tied to zero).
// Revision : 1.0  initial release
// ============================================================================
module collision_detect #(
    parameter logic [11:0] OBST_COLOR = 12'h000,
    parameter int          LANDER_W   = 32,
    parameter int          LANDER_H   = 32,
    parameter int          PAD_X      = 630,
    parameter int          PAD_Y      = 550,
    parameter int          PAD_W      = 115
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] lander_x,
    input  logic [10:0] lander_y,
    output logic        result_valid,
    output logic        crash,
    output logic        landed,
    output logic [15:0] hit_count,
    output logic [10:0] hit_x,
    output logic [10:0] hit_y
);

    // Box and pad arithmetic is 12 bits wide so edges near 2047 never wrap.
    localparam logic [11:0] C_LANDER_W = 12'(LANDER_W);
    localparam logic [11:0] C_LANDER_H = 12'(LANDER_H);
    localparam logic [11:0] C_PAD_X    = 12'(PAD_X);
    localparam logic [11:0] C_PAD_Y    = 12'(PAD_Y);
    localparam logic [11:0] C_PAD_R    = 12'(PAD_X + PAD_W);
    localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_SCAN       = 2'd2,
        S_REPORT     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_start;
    logic        w_load;

    logic [10:0] r_hcount_d;
    logic [10:0] r_vcount_d;
    logic        r_vblnk_d;
    logic [11:0] r_rgb_d;
    logic        r_vblnk_q;

    logic [10:0] r_x_lat;
    logic [10:0] r_y_lat;
    logic [15:0] r_acc;

    logic        r_crash;
    logic        r_landed;
    logic [15:0] r_hit_count;

    logic        w_vblnk_rise;
    logic        w_vblnk_fall;
    logic [11:0] w_x_lo;
    logic [11:0] w_x_hi;
    logic [11:0] w_y_lo;
    logic [11:0] w_y_hi;
    logic [11:0] w_hc;
    logic [11:0] w_vc;
    logic        w_in_box;
    logic        w_hit;
    logic        w_crash_next;
    logic        w_landed_next;

    // ------------------------------------------------------------------
    // Stage 1: register the pixel stream; r_vblnk_q gives edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount_d <= '0;
            r_vcount_d <= '0;
            r_vblnk_d  <= 1'b0;
            r_rgb_d    <= '0;
            r_vblnk_q  <= 1'b0;
        end else begin
            r_hcount_d <= hcount_in;
            r_vcount_d <= vcount_in;
            r_vblnk_d  <= vblnk_in;
            r_rgb_d    <= rgb_in;
            r_vblnk_q  <= r_vblnk_d;
        end
    end

    assign w_vblnk_rise = r_vblnk_d & ~r_vblnk_q;
    assign w_vblnk_fall = ~r_vblnk_d & r_vblnk_q;

    // ------------------------------------------------------------------
    // Stage 2: hit test against the box latched at frame start
    // ------------------------------------------------------------------
    assign w_x_lo = {1'b0, r_x_lat};
    assign w_y_lo = {1'b0, r_y_lat};
    assign w_x_hi = w_x_lo + C_LANDER_W;
    assign w_y_hi = w_y_lo + C_LANDER_H;
    assign w_hc   = {1'b0, r_hcount_d};
    assign w_vc   = {1'b0, r_vcount_d};

    assign w_in_box = (w_hc >= w_x_lo) && (w_hc < w_x_hi) &&
                      (w_vc >= w_y_lo) && (w_vc < w_y_hi);

    assign w_hit = (r_state == S_SCAN) && (r_rgb_d == OBST_COLOR) &&
                   !r_vblnk_d && w_in_box;

    assign w_crash_next  = (r_acc != 16'd0);
    assign w_landed_next = !w_crash_next && (w_y_hi == C_PAD_Y) &&
                           (w_x_lo >= C_PAD_X) && (w_x_hi <= C_PAD_R);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // enable low overrides every state, so an aborted frame never reports.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        if (!enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_WAIT_FRAME;
                end
                S_WAIT_FRAME: begin
                    if (w_vblnk_fall) begin
                        w_state_next = S_SCAN;
                        w_start      = 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_vblnk_rise) begin
                        w_state_next = S_REPORT;
                        w_load       = 1'b1;
                    end
                end
                S_REPORT: begin
                    w_state_next = S_WAIT_FRAME;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_lat <= '0;
            r_y_lat <= '0;
        end else if (w_start) begin
            r_x_lat <= lander_x;
            r_y_lat <= lander_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_start) begin
            r_acc <= '0;
        end else if (w_hit && (r_acc != C_CNT_MAX)) begin
            r_acc <= r_acc + 16'd1;
        end
    end

    // Results load on entry to REPORT so they are valid during the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crash     <= 1'b0;
            r_landed    <= 1'b0;
            r_hit_count <= '0;
        end else if (w_load) begin
            r_crash     <= w_crash_next;
            r_landed    <= w_landed_next;
            r_hit_count <= r_acc;
        end
    end

    assign result_valid = (r_state == S_REPORT);
    assign crash        = r_crash;
    assign landed       = r_landed;
    assign hit_count    = r_hit_count;

`ifdef COLLISION_FIRST_HIT_EN
    logic        r_fh_seen;
    logic [10:0] r_fh_x;
    logic [10:0] r_fh_y;
    logic [10:0] r_hit_x;
    logic [10:0] r_hit_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fh_seen <= 1'b0;
            r_fh_x    <= '0;
            r_fh_y    <= '0;
        end else if (w_start) begin
            r_fh_seen <= 1'b0;
            r_fh_x    <= '0;
            r_fh_y    <= '0;
        end else if (w_hit && !r_fh_seen) begin
            r_fh_seen <= 1'b1;
            r_fh_x    <= r_hcount_d;
            r_fh_y    <= r_vcount_d;
        end
    end

    // Capture registers are cleared at frame start, so a hit-free frame reports 0,0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_x <= '0;
            r_hit_y <= '0;
        end else if (w_load) begin
            r_hit_x <= r_fh_x;
            r_hit_y <= r_fh_y;
        end
    end

    assign hit_x = r_hit_x;
    assign hit_y = r_hit_y;
`else
    assign hit_x = 11'd0;
    assign hit_y = 11'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_collision_detect.sv
`default_nettype none
// Testbench for collision_detect: frame-level stimulus with a pixel model
// feeding a scoreboard of expected per-frame reports.
module tb_collision_detect;

    localparam int PAD_X = 630;
    localparam int PAD_Y = 550;
    localparam int PAD_W = 115;
`ifdef COLLISION_FIRST_HIT_EN
    localparam bit FH_EN = 1'b1;
`else
    localparam bit FH_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        en_big   = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        vblnk_in = 1'b1;
    logic [11:0] rgb_in   = 12'hFFF;
    logic [10:0] lander_x = '0;
    logic [10:0] lander_y = '0;

    logic        rv0, crash0, landed0;
    logic [15:0] cnt0;
    logic [10:0] hx0, hy0;
    logic        rv1, crash1, landed1;
    logic [15:0] cnt1;
    logic [10:0] hx1, hy1;

    collision_detect u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .lander_x(lander_x), .lander_y(lander_y),
        .result_valid(rv0), .crash(crash0), .landed(landed0),
        .hit_count(cnt0), .hit_x(hx0), .hit_y(hy0)
    );

    collision_detect #(.LANDER_W(300), .LANDER_H(300)) u_dut_big (
        .clk(clk), .rst_n(rst_n), .enable(en_big),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .lander_x(lander_x), .lander_y(lander_y),
        .result_valid(rv1), .crash(crash1), .landed(landed1),
        .hit_count(cnt1), .hit_x(hx1), .hit_y(hy1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic        crash;
        logic        landed;
        logic [15:0] cnt;
        logic [10:0] hx;
        logic [10:0] hy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last0;
    exp_t e0, e1;

    task automatic cmp_report(input string u, input exp_t e, input logic c, input logic l,
                              input logic [15:0] n, input logic [10:0] x, input logic [10:0] y);
        chk_eq({u, ".latency"}, cyc, e.cyc);
        chk_eq({u, ".crash"},   32'(c), 32'(e.crash));
        chk_eq({u, ".landed"},  32'(l), 32'(e.landed));
        chk_eq({u, ".count"},   32'(n), 32'(e.cnt));
        chk_eq({u, ".hit_x"},   32'(x), 32'(e.hx));
        chk_eq({u, ".hit_y"},   32'(y), 32'(e.hy));
    endtask

    // Scoreboard: every result_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rv0) begin
            if (q0.size() == 0) chk_eq("u0.spurious_valid", 32'(rv0), 32'd0);
            else begin
                e0 = q0.pop_front();
                cmp_report("u0", e0, crash0, landed0, cnt0, hx0, hy0);
            end
        end else if (q0.size() != 0 && cyc > q0[0].cyc) begin
            chk_eq("u0.missing_valid", 32'(rv0), 32'd1);
            void'(q0.pop_front());
        end
        if (rv1) begin
            if (q1.size() == 0) chk_eq("u1.spurious_valid", 32'(rv1), 32'd0);
            else begin
                e1 = q1.pop_front();
                cmp_report("u1", e1, crash1, landed1, cnt1, hx1, hy1);
            end
        end else if (q1.size() != 0 && cyc > q1[0].cyc) begin
            chk_eq("u1.missing_valid", 32'(rv1), 32'd1);
            void'(q1.pop_front());
        end
    end

    task automatic put(input int x, input int y, input logic vb, input logic [11:0] c);
        @(posedge clk);
        #1;
        hcount_in = 11'(x);
        vcount_in = 11'(y);
        vblnk_in  = vb;
        rgb_in    = c;
    endtask

    function automatic logic [11:0] pix(input int x, input int y,
                                        input int ox0, input int ox1, input int oy0, input int oy1);
        if (x >= ox0 && x < ox1 && y >= oy0 && y < oy1) return 12'h000;
        if (y >= PAD_Y && y < PAD_Y + 4 && x >= PAD_X && x < PAD_X + PAD_W) return 12'h0F0;
        return 12'hFFF;
    endfunction

    function automatic exp_t mk_exp(input int lx, input int ly, input int w, input int h,
                                    input int cnt, input bit fh, input int fx, input int fy, input int at);
        exp_t e;
        e.cyc    = at;
        e.crash  = (cnt != 0);
        e.landed = (cnt == 0) && (ly + h == PAD_Y) && (lx >= PAD_X) && (lx + w <= PAD_X + PAD_W);
        e.cnt    = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
        e.hx     = (FH_EN && fh) ? 11'(fx) : 11'd0;
        e.hy     = (FH_EN && fh) ? 11'(fy) : 11'd0;
        return e;
    endfunction

    // One frame: leading vblank, active scan of [x0,x1)x[y0,y1), trailing vblank.
    // Obstacle pixels are also driven inside the box during vblank; they must not count.
    task automatic run_frame(input int lx, input int ly, input int x0, input int x1,
                             input int y0, input int y1, input int ox0, input int ox1,
                             input int oy0, input int oy1, input int move_at,
                             input int kill_at, input int rst_at, input bit big);
        int   idx = 0;
        int   cm = 0, cb = 0;
        bit   fm = 0, fb = 0;
        int   fmx = 0, fmy = 0, fbx = 0, fby = 0;
        bit   aborted = 0;
        logic [11:0] c;
        enable   = 1'b1;
        en_big   = big;
        lander_x = 11'(lx);
        lander_y = 11'(ly);
        repeat (4) put(lx + 1, ly + 1, 1'b1, 12'h000);
        repeat (2) put(0, 0, 1'b0, 12'hFFF);
        for (int y = y0; y < y1; y++) begin
            for (int x = x0; x < x1; x++) begin
                c = pix(x, y, ox0, ox1, oy0, oy1);
                if (idx == move_at) lander_x = 11'(lx + 100);
                if (idx == kill_at) begin
                    enable  = 1'b0;
                    aborted = 1'b1;
                end
                if (idx == rst_at) begin
                    rst_n   = 1'b0;
                    aborted = 1'b1;
                    #1;
                    chk_eq("rst.result_valid", 32'(rv0), 32'd0);
                    chk_eq("rst.crash",        32'(crash0), 32'd0);
                    chk_eq("rst.landed",       32'(landed0), 32'd0);
                    chk_eq("rst.hit_count",    32'(cnt0), 32'd0);
                    chk_eq("rst.hit_x",        32'(hx0), 32'd0);
                    chk_eq("rst.hit_y",        32'(hy0), 32'd0);
                end
                if (idx == rst_at + 3) rst_n = 1'b1;
                put(x, y, 1'b0, c);
                if (c == 12'h000) begin
                    if (x >= lx && x < lx + 32 && y >= ly && y < ly + 32) begin
                        cm++;
                        if (!fm) begin fm = 1; fmx = x; fmy = y; end
                    end
                    if (x >= lx && x < lx + 300 && y >= ly && y < ly + 300) begin
                        cb++;
                        if (!fb) begin fb = 1; fbx = x; fby = y; end
                    end
                end
                idx++;
            end
        end
        put(lx + 1, ly + 1, 1'b1, 12'h000);
        if (!aborted) begin
            last0 = mk_exp(lx, ly, 32, 32, cm, fm, fmx, fmy, cyc + 2);
            q0.push_back(last0);
            if (big) q1.push_back(mk_exp(lx, ly, 300, 300, cb, fb, fbx, fby, cyc + 2));
        end
        repeat (6) put(lx + 1, ly + 1, 1'b1, 12'h000);
        en_big = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_eq("init.result_valid", 32'(rv0), 32'd0);
        chk_eq("init.crash",        32'(crash0), 32'd0);
        chk_eq("init.hit_count",    32'(cnt0), 32'd0);
        rst_n = 1'b1;
        // clean frame
        run_frame(100, 100, 98, 134, 98, 134, 0, 0, 0, 0, -1, -1, -1, 1'b0);
        // overlap: obstacle from (200,250) extends past the box edge
        run_frame(190, 240, 186, 226, 236, 276, 200, 260, 250, 310, -1, -1, -1, 1'b0);
        // reset in the middle of a frame; that frame must not report
        run_frame(190, 240, 186, 226, 236, 276, 200, 260, 250, 310, -1, -1, 800, 1'b0);
        // landing exactly on the pad, then one pixel too low
        run_frame(650, 518, 646, 686, 514, 556, 0, 0, 0, 0, -1, -1, -1, 1'b0);
        run_frame(650, 519, 646, 686, 514, 556, 0, 0, 0, 0, -1, -1, -1, 1'b0);
        // lander moves mid-frame: latched box at x=100 must be used
        run_frame(100, 100, 98, 134, 98, 134, 120, 140, 100, 110, 648, -1, -1, 1'b0);
        // enable drops mid-frame: no report, outputs keep the previous result
        run_frame(100, 100, 98, 134, 98, 134, 98, 134, 98, 134, -1, 648, -1, 1'b0);
        chk_eq("hold.crash",     32'(crash0),  32'(last0.crash));
        chk_eq("hold.landed",    32'(landed0), 32'(last0.landed));
        chk_eq("hold.hit_count", 32'(cnt0),    32'(last0.cnt));
        chk_eq("hold.hit_x",     32'(hx0),     32'(last0.hx));
        // saturation on the 300x300 instance, all pixels obstacle
        run_frame(10, 10, 20, 276, 20, 277, 0, 2000, 0, 2000, -1, -1, -1, 1'b1);
        repeat (10) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
